// File: rtl/pwl_table_loader_pkg.sv
// Shared constants and types for the PWL coefficient table loader.
// Stream layout: x1..x8 at words 0..7, then interleaved m/c pairs
// (m1 at word 8, c1 at word 9, m2 at word 10, ...).
package pwl_pkg;

    localparam int NBRK      = 8;
    localparam int NSEG      = 9;
    localparam int NWORDS    = NBRK + 2 * NSEG;

    localparam int X_BASE    = 0;
    localparam int M_BASE    = NBRK;
    localparam int C_BASE    = NBRK + 1;
    localparam int MC_STRIDE = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_CHECK,
        ST_COMMIT,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_EARLY_LAST = 2'd1;
    localparam logic [1:0] ERR_NO_LAST    = 2'd2;
    localparam logic [1:0] ERR_ORDER      = 2'd3;

    // Stream index of slope m<seg> (seg counts from 1).
    function automatic int m_idx(input int seg);
        return M_BASE + MC_STRIDE * (seg - 1);
    endfunction

    // Stream index of intercept c<seg> (seg counts from 1).
    function automatic int c_idx(input int seg);
        return C_BASE + MC_STRIDE * (seg - 1);
    endfunction

endpackage

// File: rtl/pwl_table_loader_order_check.sv
// Sequential breakpoint order checker: after start_i it examines one
// adjacent pair per cycle (x[k+1] > x[k], signed, strict) and reports
// pass_o on the last pair or fail_o on the first bad pair.
module pwl_order_check
    import pwl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic signed [WIDTH-1:0] x_i [NBRK],
    output logic                    pass_o,
    output logic                    fail_o
);

    // k_q holds the zero-based index of the lower breakpoint of the pair
    logic       active_q;
    logic [2:0] k_q;
    logic       ok;

    assign ok     = x_i[k_q + 3'd1] > x_i[k_q];
    assign pass_o = active_q && ok && (k_q == 3'(NBRK - 2));
    assign fail_o = active_q && !ok;

    // Walk the pairs one per cycle, stopping on the first failure or the last pair
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            k_q      <= 3'd0;
        end else if (start_i) begin
            active_q <= 1'b1;
            k_q      <= 3'd0;
        end else if (active_q) begin
            if (!ok || (k_q == 3'(NBRK - 2))) begin
                active_q <= 1'b0;
            end else begin
                k_q <= k_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/pwl_table_loader.sv
// PWL coefficient table loader: stages a 26-word stream in a shadow bank
// and commits it atomically to the active bank that feeds the selector.
// Optional feature macro: PWL_ORDER_CHECK_EN (strict ascending breakpoint
// check before commit; without it any breakpoint order is committed).
module pwl_table_loader
    import pwl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_data,
    input  logic                    s_last,
    output logic signed [WIDTH-1:0] x1, x2, x3, x4, x5, x6, x7, x8,
    output logic signed [WIDTH-1:0] m1, m2, m3, m4, m5, m6, m7, m8, m9,
    output logic signed [WIDTH-1:0] c1, c2, c3, c4, c5, c6, c7, c8, c9,
    output logic                    table_valid,
    output logic                    busy,
    output logic                    err,
    output logic [1:0]              err_code
);

    state_t                  state_q, state_d;
    logic [4:0]              count_q, count_d;
    logic [1:0]              err_code_q, err_code_d;
    logic                    s_ready_q, busy_q, err_q, table_valid_q;
    logic                    wr_en;
    logic                    accept;
    logic signed [WIDTH-1:0] shadow_q [NWORDS];
    logic signed [WIDTH-1:0] active_q [NWORDS];

    assign accept = s_valid && s_ready_q;

`ifdef PWL_ORDER_CHECK_EN
    logic                    chk_start, chk_pass, chk_fail;
    logic signed [WIDTH-1:0] brk [NBRK];

    // Present the staged breakpoints to the order checker
    always_comb begin
        for (int i = 0; i < NBRK; i++) begin
            brk[i] = shadow_q[X_BASE + i];
        end
    end

    assign chk_start = (state_q == ST_LOAD) && (state_d == ST_CHECK);

    pwl_order_check #(
        .WIDTH (WIDTH)
    ) u_order_check (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (chk_start),
        .x_i     (brk),
        .pass_o  (chk_pass),
        .fail_o  (chk_fail)
    );
`endif

    // Next-state, word counter and error-cause decode
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        err_code_d = err_code_q;
        wr_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    count_d = 5'd1;
                    if (s_last) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_EARLY_LAST;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 5'd1;
                    if (count_q == 5'(NWORDS - 1)) begin
                        if (s_last) begin
`ifdef PWL_ORDER_CHECK_EN
                            state_d = ST_CHECK;
`else
                            state_d = ST_COMMIT;
`endif
                        end else begin
                            state_d    = ST_DRAIN;
                            err_code_d = ERR_NO_LAST;
                        end
                    end else if (s_last) begin
                        state_d    = ST_ERR;
                        err_code_d = ERR_EARLY_LAST;
                    end
                end
            end
            ST_DRAIN: begin
                // Surplus words are swallowed until the stream closes
                if (accept && s_last) begin
                    state_d = ST_ERR;
                end
            end
            ST_CHECK: begin
`ifdef PWL_ORDER_CHECK_EN
                if (chk_fail) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_ORDER;
                end else if (chk_pass) begin
                    state_d = ST_COMMIT;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                count_d = 5'd0;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
                count_d = 5'd0;
            end
            default: begin
                state_d = ST_IDLE;
                count_d = 5'd0;
            end
        endcase
    end

    // State, registered handshake/status outputs, shadow staging and atomic commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            count_q       <= 5'd0;
            err_code_q    <= ERR_NONE;
            s_ready_q     <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            table_valid_q <= 1'b0;
            for (int i = 0; i < NWORDS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            err_code_q <= err_code_d;
            s_ready_q  <= (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_DRAIN);
            busy_q     <= (state_d != ST_IDLE);
            err_q      <= (state_d == ST_ERR);
            if (wr_en) begin
                shadow_q[count_q] <= s_data;
            end
            if (state_q == ST_COMMIT) begin
                active_q      <= shadow_q;
                table_valid_q <= 1'b1;
            end
        end
    end

    assign s_ready     = s_ready_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign table_valid = table_valid_q;

    assign x1 = active_q[X_BASE + 0];
    assign x2 = active_q[X_BASE + 1];
    assign x3 = active_q[X_BASE + 2];
    assign x4 = active_q[X_BASE + 3];
    assign x5 = active_q[X_BASE + 4];
    assign x6 = active_q[X_BASE + 5];
    assign x7 = active_q[X_BASE + 6];
    assign x8 = active_q[X_BASE + 7];

    assign m1 = active_q[m_idx(1)];
    assign m2 = active_q[m_idx(2)];
    assign m3 = active_q[m_idx(3)];
    assign m4 = active_q[m_idx(4)];
    assign m5 = active_q[m_idx(5)];
    assign m6 = active_q[m_idx(6)];
    assign m7 = active_q[m_idx(7)];
    assign m8 = active_q[m_idx(8)];
    assign m9 = active_q[m_idx(9)];

    assign c1 = active_q[c_idx(1)];
    assign c2 = active_q[c_idx(2)];
    assign c3 = active_q[c_idx(3)];
    assign c4 = active_q[c_idx(4)];
    assign c5 = active_q[c_idx(5)];
    assign c6 = active_q[c_idx(6)];
    assign c7 = active_q[c_idx(7)];
    assign c8 = active_q[c_idx(8)];
    assign c9 = active_q[c_idx(9)];

endmodule

// File: tb/tb_pwl_table_loader.sv
// Directed bench for pwl_table_loader; expectations follow the build's
// PWL_ORDER_CHECK_EN setting.
module tb_pwl_table_loader;

`ifdef PWL_ORDER_CHECK_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n, s_valid, s_ready, s_last;
    logic signed [31:0] s_data;
    logic signed [31:0] x1, x2, x3, x4, x5, x6, x7, x8;
    logic signed [31:0] m1, m2, m3, m4, m5, m6, m7, m8, m9;
    logic signed [31:0] c1, c2, c3, c4, c5, c6, c7, c8, c9;
    logic table_valid, busy, err;
    logic [1:0] err_code;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int ready_low = 0;

    logic [31:0] obs [26];
    logic [31:0] exp_act [26];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwl_table_loader #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7), .x8(x8),
        .m1(m1), .m2(m2), .m3(m3), .m4(m4), .m5(m5), .m6(m6), .m7(m7), .m8(m8), .m9(m9),
        .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7), .c8(c8), .c9(c9),
        .table_valid(table_valid), .busy(busy), .err(err), .err_code(err_code)
    );

    // Observed active bank in stream order
    assign obs[0] = x1;  assign obs[1] = x2;  assign obs[2] = x3;  assign obs[3] = x4;
    assign obs[4] = x5;  assign obs[5] = x6;  assign obs[6] = x7;  assign obs[7] = x8;
    assign obs[8]  = m1; assign obs[9]  = c1; assign obs[10] = m2; assign obs[11] = c2;
    assign obs[12] = m3; assign obs[13] = c3; assign obs[14] = m4; assign obs[15] = c4;
    assign obs[16] = m5; assign obs[17] = c5; assign obs[18] = m6; assign obs[19] = c6;
    assign obs[20] = m7; assign obs[21] = c7; assign obs[22] = m8; assign obs[23] = c8;
    assign obs[24] = m9; assign obs[25] = c9;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Word i of table tbl. x1=-4.0 .. x8=+3.0 in Q4.27 (x1=0xE000_0000);
    // table 1 repeats x3 in x4; words past 26 are drain filler.
    function automatic logic [31:0] word_of(input int tbl, input int i);
        int xi, seg, isc;
        if (i < 8) begin
            xi = (tbl == 1 && i == 3) ? 2 : i;
            return 32'((xi - 4) * (1 << 27));
        end else if (i < 26) begin
            seg = (i - 8) / 2 + 1;
            isc = (i - 8) % 2;
            return 32'h0100_0000 + 32'(tbl << 16) + 32'(isc << 12) + 32'(seg << 4);
        end
        return 32'hDEAD_0000 + 32'(i);
    endfunction

    task automatic set_exp(input int tbl);
        for (int i = 0; i < 26; i++) exp_act[i] = word_of(tbl, i);
    endtask

    task automatic check_active(input string tag);
        for (int i = 0; i < 26; i++) check_val($sformatf("%s_w%0d", tag, i), obs[i], exp_act[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic last, input bit mid, output bit ok);
        int waits;
        waits = 0;
        ok = 1'b0;
        s_valid = 1'b1; s_data = d; s_last = last;
        @(negedge clk);
        if (mid && !s_ready) ready_low++;
        while (!s_ready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (s_ready) begin
            ok = 1'b1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    // Stream nwords of table tbl, s_last on word last_at (1-based, 0 = none)
    task automatic load(input int tbl, input int nwords, input int last_at, input bit gaps,
                        output int t_acc, output int n_acc);
        bit ok;
        n_acc = 0;
        for (int i = 0; i < nwords; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 99) < 30) begin
                @(negedge clk);
                if (!s_ready) ready_low++;
                @(posedge clk);
                #1;
            end
            push(word_of(tbl, i), (i + 1 == last_at), (i > 0), ok);
            if (!ok) begin
                check_val("accept_timeout", 32'(i), 32'(nwords));
                break;
            end
            n_acc++;
        end
        t_acc = cyc;
    endtask

    task automatic wait_err(input int t0, output int dt);
        int k;
        k = 0;
        while (!err && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        dt = err ? (cyc - t0) : -1;
    endtask

    task automatic wait_tv(input int t0, output int dt);
        int k;
        k = 0;
        while (!table_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        dt = table_valid ? (cyc - t0) : -1;
    endtask

    initial begin
        int t, dt, na;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        for (int i = 0; i < 26; i++) exp_act[i] = '0;
        idle(3);
        check_val("rst_s_ready", 32'(s_ready), 32'd0);
        check_val("rst_table_valid", 32'(table_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_err_code", 32'(err_code), 32'd0);
        check_active("rst");
        rst_n = 1'b1;
        idle(1);
        check_val("ready_after_rst", 32'(s_ready), 32'd1);

        // Clean ascending table A
        load(0, 26, 26, 0, t, na);
        check_val("t1_accepts", 32'(na), 32'd26);
        check_val("t1_ready_gap", 32'(s_ready), 32'd0);
        check_val("t1_busy", 32'(busy), 32'd1);
        check_val("t1_x1_hand", word_of(0, 0), 32'hE000_0000);
        wait_tv(t, dt);
        check_val("t1_tv_latency", 32'(dt), 32'(LAT));
        set_exp(0);
        check_active("t1");

        // Table B with x4 == x3
        load(1, 26, 26, 0, t, na);
`ifdef PWL_ORDER_CHECK_EN
        wait_err(t, dt);
        check_val("t2_err_time", 32'(dt), 32'd3);
        check_val("t2_err_code", 32'(err_code), 32'd3);
        idle(1);
        check_val("t2_err_pulse", 32'(err), 32'd0);
`else
        idle(4);
        set_exp(1);
`endif
        check_val("t2_tv", 32'(table_valid), 32'd1);
        check_active("t2");

        // Early s_last on word 10, then a clean table 3
        load(2, 10, 10, 0, t, na);
        wait_err(t, dt);
        check_val("t3_err_time", 32'(dt), 32'd0);
        check_val("t3_err_code", 32'(err_code), 32'd1);
        check_active("t3_hold");
        load(3, 26, 26, 0, t, na);
        idle(LAT + 2);
        set_exp(3);
        check_active("t3_next");
        check_val("t3_code_held", 32'(err_code), 32'd1);

        // 30 words, s_last only on word 30
        load(2, 30, 30, 0, t, na);
        check_val("t4_accepts", 32'(na), 32'd30);
        wait_err(t, dt);
        check_val("t4_err_time", 32'(dt), 32'd0);
        check_val("t4_err_code", 32'(err_code), 32'd2);
        idle(LAT + 2);
        check_val("t4_tv", 32'(table_valid), 32'd1);
        check_active("t4");

        // Table A again with random valid gaps
        ready_low = 0;
        load(0, 26, 26, 1, t, na);
        idle(LAT + 2);
        set_exp(0);
        check_active("t5");
        check_val("t5_ready_low", 32'(ready_low), 32'd0);

        // Reset at word 15 of a load
        load(2, 14, 0, 0, t, na);
        s_valid = 1'b1; s_data = word_of(2, 14); rst_n = 1'b0;
        idle(1);
        s_valid = 1'b0;
        for (int i = 0; i < 26; i++) exp_act[i] = '0;
        check_active("t6_rst");
        check_val("t6_tv", 32'(table_valid), 32'd0);
        check_val("t6_err", 32'(err), 32'd0);
        check_val("t6_err_code", 32'(err_code), 32'd0);
        check_val("t6_busy", 32'(busy), 32'd0);
        check_val("t6_ready", 32'(s_ready), 32'd0);
        rst_n = 1'b1;
        load(3, 26, 26, 0, t, na);
        wait_tv(t, dt);
        check_val("t6_tv_latency", 32'(dt), 32'(LAT));
        set_exp(3);
        check_active("t6_reload");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
